// File: rtl/spi_v3_spi_master_pkg.sv
// Shared types and sizing helpers for the SPI_v3 master.
//   state_t  : master FSM states (IDLE..GUARD)
//   cnt_w()  : counter width able to hold 0..n-1 (minimum 1 bit)
// Optional build macro used by this block: SPI_V3_SPI_MASTER_PARITY_EN
package spi_v3_spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SCLK_HI = 3'd2,
    SCLK_LO = 3'd3,
    RESP    = 3'd4,
    GUARD   = 3'd5
  } state_t;

  localparam int unsigned NBITS_DEFAULT       = 34;
  localparam int unsigned HALF_PERIOD_DEFAULT = 4;

  // Width of a counter that must represent the values 0..n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Default widths: half-period counter ($clog2(half_period)) and bit
  // counter ($clog2(nbits+1), since it must reach nbits itself).
  localparam int unsigned HC_W_DEFAULT = cnt_w(HALF_PERIOD_DEFAULT);
  localparam int unsigned BC_W_DEFAULT = cnt_w(NBITS_DEFAULT + 1);

endpackage

// File: rtl/spi_v3_spi_master_clkdiv.sv
// Half-period counter for the SPI_v3 master.
//   clk, reset   : clock, async active-high reset
//   en           : count while high
//   clr          : force the count back to zero
//   phase_done_c : high in the last cycle of each half_period-long phase
module spi_v3_spi_master_clkdiv
  import spi_v3_spi_master_pkg::*;
#(
  parameter int unsigned half_period = HALF_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic phase_done_c
);

  localparam int unsigned HC_W = cnt_w(half_period);

  logic [HC_W-1:0] hc;

  assign phase_done_c = en && (hc == HC_W'(half_period - 1));

  // Wraps to zero at the end of each phase so the next phase starts clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc <= '0;
    end else if (clr || phase_done_c) begin
      hc <= '0;
    end else if (en) begin
      hc <= hc + HC_W'(1);
    end
  end

endmodule

// File: rtl/spi_v3_spi_master.sv
// SPI_v3 master (mode 0, MSB first).
//   clk, reset                  : clock, async active-high reset
//   recv_val/recv_rdy/recv_msg  : request frame in (val/rdy)
//   send_val/send_rdy/send_msg  : captured frame out (val/rdy)
//   cs, sclk, mosi, miso        : SPI pins (cs active-low, sclk idle low)
//   resp_parity                 : XOR of send_msg, only with
//                                 SPI_V3_SPI_MASTER_PARITY_EN defined
module spi_v3_spi_master
  import spi_v3_spi_master_pkg::*;
#(
  parameter int unsigned nbits       = NBITS_DEFAULT,
  parameter int unsigned half_period = HALF_PERIOD_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [nbits-1:0] recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [nbits-1:0] send_msg,
  output logic             cs,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
`ifdef SPI_V3_SPI_MASTER_PARITY_EN
  ,
  output logic             resp_parity
`endif
);

  localparam int unsigned BC_W = cnt_w(nbits + 1);

  state_t           state, state_next;
  logic [nbits-1:0] tx, tx_next;
  logic [nbits-1:0] cap;
  logic [BC_W-1:0]  bc;
  logic             phase_done_c;
  logic             div_en;
  logic             frame_next;
  logic             last_bit;

  assign recv_rdy = (state == IDLE) && !reset;
  assign div_en   = (state == SETUP) || (state == SCLK_HI) ||
                    (state == SCLK_LO) || (state == GUARD);
  assign last_bit = (bc == BC_W'(nbits));

  spi_v3_spi_master_clkdiv #(
    .half_period (half_period)
  ) u_clkdiv (
    .clk          (clk),
    .reset        (reset),
    .en           (div_en),
    .clr          (!div_en),
    .phase_done_c (phase_done_c)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and next tx shift value.
  always_comb begin
    state_next = state;
    tx_next    = tx;
    case (state)
      IDLE: begin
        if (recv_val && recv_rdy) begin
          state_next = SETUP;
          tx_next    = recv_msg;
        end
      end
      SETUP: begin
        if (phase_done_c) state_next = SCLK_HI;
      end
      SCLK_HI: begin
        if (phase_done_c) begin
          state_next = SCLK_LO;
          tx_next    = {tx[nbits-2:0], 1'b0};
        end
      end
      SCLK_LO: begin
        if (phase_done_c) state_next = last_bit ? RESP : SCLK_HI;
      end
      RESP: begin
        if (send_rdy) state_next = GUARD;
      end
      GUARD: begin
        if (phase_done_c) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign frame_next = (state_next == SETUP) || (state_next == SCLK_HI) ||
                      (state_next == SCLK_LO);

  // Datapath and pin registers; pins follow the next state so they change
  // on the same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx          <= '0;
      cap         <= '0;
      bc          <= '0;
      send_msg    <= '0;
      send_val    <= 1'b0;
      cs          <= 1'b1;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
`ifdef SPI_V3_SPI_MASTER_PARITY_EN
      resp_parity <= 1'b0;
`endif
    end else begin
      tx <= tx_next;
      if (state == IDLE && recv_val && recv_rdy) begin
        cap <= '0;
        bc  <= '0;
      end else if (state == SCLK_HI && phase_done_c) begin
        cap <= {cap[nbits-2:0], miso};
        bc  <= bc + BC_W'(1);
      end
      if (state == SCLK_LO && phase_done_c && last_bit) begin
        send_msg    <= cap;
`ifdef SPI_V3_SPI_MASTER_PARITY_EN
        resp_parity <= ^cap;
`endif
      end
      send_val <= (state_next == RESP);
      cs       <= !frame_next;
      sclk     <= (state_next == SCLK_HI);
      mosi     <= frame_next ? tx_next[nbits-1] : 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_v3_spi_master.sv
// Directed bench for spi_v3_spi_master (nbits=8, half_period=2).
module tb_spi_v3_spi_master;

  localparam int unsigned NB = 8;
  localparam int unsigned HP = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          recv_val;
  logic          recv_rdy;
  logic [NB-1:0] recv_msg;
  logic          send_val;
  logic          send_rdy;
  logic [NB-1:0] send_msg;
  logic          cs;
  logic          sclk;
  logic          mosi;
  logic          miso;
  logic          miso_drv;
  logic          loop_en;
`ifdef SPI_V3_SPI_MASTER_PARITY_EN
  logic          resp_parity;
`endif

  int            vectors = 0;
  int            miscompares = 0;
  int            cs_low, cs_hi_run, last_hi_run, rise_cnt, cyc;
  logic          sclk_prev, saw_rdy, stable;
  logic [NB-1:0] mosi_log;

  assign miso = loop_en ? mosi : miso_drv;

  spi_v3_spi_master #(
    .nbits       (NB),
    .half_period (HP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg),
    .cs       (cs),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso)
`ifdef SPI_V3_SPI_MASTER_PARITY_EN
    ,
    .resp_parity (resp_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then sample pins and update the pin trackers.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!cs) begin
      cs_low++;
      if (cs_hi_run > 0) begin
        last_hi_run = cs_hi_run;
        cs_hi_run   = 0;
      end
    end else begin
      cs_hi_run++;
    end
    if (sclk && !sclk_prev) begin
      rise_cnt++;
      mosi_log = {mosi_log[NB-2:0], mosi};
    end
    sclk_prev = sclk;
    if (recv_rdy) saw_rdy = 1'b1;
  endtask

  task automatic wait_send(output int n);
    n = 0;
    while (!send_val && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic send_frame(input logic [NB-1:0] d);
    int n;
    n = 0;
    while (!recv_rdy && n < 50) begin
      tick();
      n++;
    end
    recv_val = 1'b1;
    recv_msg = d;
    tick();
    recv_val = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    recv_val    = 1'b0;
    recv_msg    = '0;
    send_rdy    = 1'b0;
    miso_drv    = 1'b1;
    loop_en     = 1'b0;
    sclk_prev   = 1'b0;
    saw_rdy     = 1'b0;
    mosi_log    = '0;
    cs_low      = 0;
    cs_hi_run   = 0;
    last_hi_run = 0;
    rise_cnt    = 0;
    cyc         = 0;

    // Reset state.
    #12;
    check("reset_cs",       64'(cs),       64'h1);
    check("reset_sclk",     64'(sclk),     64'h0);
    check("reset_mosi",     64'(mosi),     64'h0);
    check("reset_send_val", 64'(send_val), 64'h0);
    check("reset_send_msg", 64'(send_msg), 64'h0);
    check("reset_recv_rdy", 64'(recv_rdy), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("idle_recv_rdy", 64'(recv_rdy), 64'h1);

    // 0xA5 out with miso tied high.
    recv_val = 1'b1;
    recv_msg = 8'hA5;
    cs_low   = 0;
    rise_cnt = 0;
    tick();
    recv_val = 1'b0;
    check("frame_recv_rdy", 64'(recv_rdy), 64'h0);
    check("cs_fall",        64'(cs),       64'h0);
    wait_send(cyc);
    check("resp_latency",   64'(cyc + 1),  64'd35);
    check("cs_low_cycles",  64'(cs_low),   64'd34);
    check("mosi_bits",      64'(mosi_log), 64'hA5);
    check("sclk_rises",     64'(rise_cnt), 64'd8);
    check("miso_ones",      64'(send_msg), 64'hFF);
    check("resp_cs",        64'(cs),       64'h1);

    // Response held while send_rdy is low; requests ignored meanwhile.
    recv_val = 1'b1;
    recv_msg = 8'h55;
    stable   = 1'b1;
    repeat (10) begin
      tick();
      if (!send_val || send_msg !== 8'hFF || !cs || sclk || recv_rdy) stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'h1);
    recv_val = 1'b0;
    send_rdy = 1'b1;
    tick();
    send_rdy = 1'b0;
    check("hs_send_val",   64'(send_val), 64'h0);
    check("hs_send_msg",   64'(send_msg), 64'hFF);
    tick();
    check("guard_rdy",     64'(recv_rdy), 64'h0);
    tick();
    check("guard_end_rdy", 64'(recv_rdy), 64'h1);

    // Loopback, back-to-back frames.
    loop_en  = 1'b1;
    send_rdy = 1'b1;
    send_frame(8'h3C);
    saw_rdy = 1'b0;
    wait_send(cyc);
    check("loop_3c",      64'(send_msg), 64'h3C);
    check("rdy_frame_3c", 64'(saw_rdy),  64'h0);
    send_frame(8'hC3);
    check("cs_hi_gap",    64'(last_hi_run >= 3), 64'h1);
    saw_rdy = 1'b0;
    wait_send(cyc);
    check("loop_c3",      64'(send_msg), 64'hC3);
    check("rdy_frame_c3", 64'(saw_rdy),  64'h0);

    // Reset during the 4th sclk high phase.
    rise_cnt = 0;
    send_frame(8'h5A);
    cyc = 0;
    while (rise_cnt < 4 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("mid_sclk", 64'(sclk), 64'h1);
    check("mid_cs",   64'(cs),   64'h0);
    #2;
    reset = 1'b1;
    #1;
    check("abort_cs",       64'(cs),       64'h1);
    check("abort_sclk",     64'(sclk),     64'h0);
    check("abort_send_val", 64'(send_val), 64'h0);
    check("abort_recv_rdy", 64'(recv_rdy), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("post_abort_val", 64'(send_val), 64'h0);
    send_frame(8'h81);
    wait_send(cyc);
    check("loop_81", 64'(send_msg), 64'h81);
`ifdef SPI_V3_SPI_MASTER_PARITY_EN
    check("parity_81", 64'(resp_parity), 64'h0);
    send_frame(8'h07);
    wait_send(cyc);
    check("loop_07",   64'(send_msg),    64'h07);
    check("parity_07", 64'(resp_parity), 64'h1);
    send_frame(8'h03);
    wait_send(cyc);
    check("loop_03",   64'(send_msg),    64'h03);
    check("parity_03", 64'(resp_parity), 64'h0);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
